// File: rtl/axis_zmod_dac.sv
// rtl/axis_zmod_dac.sv - AXI4-Stream to 14-bit DDR Zmod DAC transmitter with power-up sequencer
// Lane A leaves on the aclk high phase and lane B on the low phase.

module axis_zmod_dac_oddr #(
   parameter int WIDTH = 1
)(
   input  logic             clk,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] cap_rise;
   logic [WIDTH-1:0] cap_fall;
   logic [WIDTH-1:0] out_rise;
   logic [WIDTH-1:0] out_fall;

   // Same-edge capture followed by the output stage, as in ODDRE1 SAME_EDGE mode.
   always_ff @(posedge clk) begin
      cap_rise <= d1;
      cap_fall <= d2;
      out_rise <= cap_rise;
      out_fall <= cap_fall;
   end

   assign q = clk ? out_rise : out_fall;
endmodule

module axis_zmod_dac #(
   parameter int DAC_DATA_WIDTH   = 14,
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int RESET_CYCLES     = 16,
   parameter int WARMUP_CYCLES    = 64,
   parameter bit OFFSET_BINARY    = 1'b1
)(
   input  logic                        aclk,
   input  logic                        areset,
   input  logic                        cfg_hold,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   output logic                        s_axis_tready,
   output logic                        dac_clk,
   output logic [DAC_DATA_WIDTH-1:0]   dac_data,
   output logic                        dac_rst,
   output logic                        sts_running,
   output logic [31:0]                 sts_underflow
);
   localparam int LW = AXIS_TDATA_WIDTH / 2;
   localparam int DW = DAC_DATA_WIDTH;
   localparam logic [DW-1:0] ZERO_CODE = OFFSET_BINARY ? {1'b1, {(DW-1){1'b0}}} : '0;

   typedef enum logic [1:0] {ST_RESET, ST_WARMUP, ST_RUN} state_t;

   state_t        state;
   logic [31:0]   cnt;
   logic [DW-1:0] pair_a;
   logic [DW-1:0] pair_b;

   // Values outside the DAC range clip to full scale instead of wrapping.
   function automatic logic [DW-1:0] conv(input logic [LW-1:0] x);
      logic [DW-1:0] r;
      if (x[LW-1:DW-1] == {(LW-DW+1){x[LW-1]}})
         r = x[DW-1:0];
      else if (x[LW-1])
         r = {1'b1, {(DW-1){1'b0}}};
      else
         r = {1'b0, {(DW-1){1'b1}}};
      if (OFFSET_BINARY)
         r[DW-1] = ~r[DW-1];
      return r;
   endfunction

   always_ff @(posedge aclk) begin
      if (areset) begin
         state         <= ST_RESET;
         cnt           <= '0;
         pair_a        <= ZERO_CODE;
         pair_b        <= ZERO_CODE;
         s_axis_tready <= 1'b0;
         dac_rst       <= 1'b1;
         sts_running   <= 1'b0;
         sts_underflow <= '0;
      end else begin
         case (state)
            ST_RESET: begin
               if (cnt == 32'(RESET_CYCLES - 1)) begin
                  state   <= ST_WARMUP;
                  cnt     <= '0;
                  dac_rst <= 1'b0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            ST_WARMUP: begin
               pair_a <= ZERO_CODE;
               pair_b <= ZERO_CODE;
               if (cnt == 32'(WARMUP_CYCLES - 1)) begin
                  state         <= ST_RUN;
                  cnt           <= '0;
                  s_axis_tready <= 1'b1;
                  sts_running   <= 1'b1;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            ST_RUN: begin
               if (s_axis_tvalid) begin
                  pair_a <= conv(s_axis_tdata[LW-1:0]);
                  pair_b <= conv(s_axis_tdata[2*LW-1:LW]);
               end else begin
                  if (!cfg_hold) begin
                     pair_a <= ZERO_CODE;
                     pair_b <= ZERO_CODE;
                  end
                  if (sts_underflow != '1)
                     sts_underflow <= sts_underflow + 32'd1;
               end
            end
            default: state <= ST_RESET;
         endcase
      end
   end

   axis_zmod_dac_oddr #(.WIDTH(DW)) u_oddr_data (
      .clk (aclk),
      .d1  (pair_a),
      .d2  (pair_b),
      .q   (dac_data)
   );

   // Forwarded clock is not reset so it keeps toggling through the whole sequence.
   axis_zmod_dac_oddr #(.WIDTH(1)) u_oddr_clk (
      .clk (aclk),
      .d1  (1'b1),
      .d2  (1'b0),
      .q   (dac_clk)
   );
endmodule

// File: tb/tb_axis_zmod_dac.sv
// tb/tb_axis_zmod_dac.sv - self-checking bench for axis_zmod_dac (offset-binary and two's-complement builds)

module tb_axis_zmod_dac;
   logic        clk = 1'b0;
   logic        areset;
   logic        cfg_hold;
   logic [31:0] tdata;
   logic        tvalid;

   logic        tready1, dclk1, rst1, run1;
   logic [13:0] data1;
   logic [31:0] und1;
   logic        tready0, dclk0, rst0, run0;
   logic [13:0] data0;
   logic [31:0] und0;

   always #5 clk = ~clk;

   axis_zmod_dac #(.OFFSET_BINARY(1'b1)) dut (
      .aclk(clk), .areset(areset), .cfg_hold(cfg_hold),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready1),
      .dac_clk(dclk1), .dac_data(data1), .dac_rst(rst1),
      .sts_running(run1), .sts_underflow(und1)
   );

   axis_zmod_dac #(.OFFSET_BINARY(1'b0)) dut_tc (
      .aclk(clk), .areset(areset), .cfg_hold(cfg_hold),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready0),
      .dac_clk(dclk0), .dac_data(data0), .dac_rst(rst0),
      .sts_running(run0), .sts_underflow(und0)
   );

   int n_checks = 0;
   int n_errors = 0;

   int          t;
   bit          mvalid = 0;
   int          since_rst = -1;
   longint      und;
   logic [27:0] p [2][3];
   logic [13:0] last_a1, last_b1, last_a0, last_b0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [13:0] ea1;
      logic [13:0] eb1;
      logic [13:0] ea0;
      logic [13:0] eb0;
   } vec_t;
   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [13:0] mconv(input logic [15:0] x, input int ob);
      int v;
      logic [13:0] c;
      v = int'($signed(x));
      if (v > 8191) v = 8191;
      if (v < -8192) v = -8192;
      c = 14'(v);
      if (ob != 0) c = c ^ 14'h2000;
      return c;
   endfunction

   function automatic logic [13:0] zcode(input int ob);
      return (ob != 0) ? 14'h2000 : 14'h0000;
   endfunction

   task automatic step();
      bit was_run;
      logic [27:0] np;
      @(posedge clk);
      was_run = mvalid && (t >= 80);
      if (areset) begin
         t = 0;
         und = 0;
         mvalid = 1;
         if (since_rst < 0) since_rst = 0; else since_rst++;
      end else if (mvalid) begin
         t++;
         since_rst++;
      end
      for (int d = 0; d < 2; d++) begin
         if (areset || !was_run)
            np = {zcode(d), zcode(d)};
         else if (tvalid)
            np = {mconv(tdata[31:16], d), mconv(tdata[15:0], d)};
         else if (cfg_hold)
            np = p[d][0];
         else
            np = {zcode(d), zcode(d)};
         p[d][2] = p[d][1];
         p[d][1] = p[d][0];
         p[d][0] = np;
      end
      if (!areset && was_run && !tvalid && und < 64'hFFFF_FFFF) und++;
      #1;
      if (mvalid) begin
         chk("tready", tready1, (t >= 80));
         chk("dac_rst", rst1, (t < 16));
         chk("sts_running", run1, (t >= 80));
         chk("sts_underflow", und1, 32'(und));
         chk("tready_tc", tready0, (t >= 80));
      end
      if (since_rst >= 2) begin
         chk("lane_a", data1, p[1][2][13:0]);
         chk("lane_a_tc", data0, p[0][2][13:0]);
         chk("dac_clk_high", dclk1, 1);
      end
      last_a1 = data1;
      last_a0 = data0;
      @(negedge clk);
      #1;
      if (since_rst >= 2) begin
         chk("lane_b", data1, p[1][2][27:14]);
         chk("lane_b_tc", data0, p[0][2][27:14]);
         chk("dac_clk_low", dclk1, 0);
      end
      last_b1 = data1;
      last_b0 = data0;
   endtask

   task automatic rand_step();
      tvalid = ($urandom_range(0, 3) != 0);
      cfg_hold = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
         0: tdata = $urandom;
         1: tdata = {{3{tdata[13]}}, 13'($urandom), {3{tdata[29]}}, 13'($urandom)};
         default: tdata = {16'($urandom_range(0, 400) - 200), 16'($urandom_range(0, 400) - 200)};
      endcase
      step();
   endtask

   initial begin
      int rise;
      vecs[0] = '{16'h7FFF, 16'h8000, 14'h3FFF, 14'h0000, 14'h1FFF, 14'h2000};
      vecs[1] = '{16'h2000, 16'hDFFF, 14'h3FFF, 14'h0000, 14'h1FFF, 14'h2000};
      vecs[2] = '{16'h0000, 16'hFFFF, 14'h2000, 14'h1FFF, 14'h0000, 14'h3FFF};
      vecs[3] = '{16'h0005, 16'hFFFB, 14'h2005, 14'h1FFB, 14'h0005, 14'h3FFB};
      vecs[4] = '{16'h1FFF, 16'hE000, 14'h3FFF, 14'h0000, 14'h1FFF, 14'h2000};
      vecs[5] = '{16'h1000, 16'hF000, 14'h3000, 14'h1000, 14'h1000, 14'h3000};

      areset = 1'b1; cfg_hold = 1'b0; tvalid = 1'b0; tdata = '0;
      repeat (4) step();
      areset = 1'b0;

      // Power-up sequence: tready must rise after edge 80 following release.
      rise = -1;
      for (int k = 1; k <= 200 && rise < 0; k++) begin
         step();
         if (tready1) rise = k;
      end
      chk("tready_rise_edge", 32'(rise), 32'd80);

      tvalid = 1'b1;
      for (int n = 0; n <= 100; n++) begin
         tdata = {16'(-n), 16'(n)};
         step();
      end

      tvalid = 1'b0; cfg_hold = 1'b1;
      repeat (10) step();
      chk("hold_a", last_a1, 14'h2064);
      chk("hold_b", last_b1, 14'h1F9C);
      cfg_hold = 1'b0;
      repeat (10) step();
      chk("zero_a", last_a1, 14'h2000);
      chk("zero_b", last_b1, 14'h2000);
      chk("underflow_count", und1, 32'd20);

      for (int i = 0; i < 6; i++) begin
         tdata = {vecs[i].b, vecs[i].a};
         tvalid = 1'b1;
         step();
         tvalid = 1'b0; cfg_hold = 1'b1;
         step();
         step();
         chk("tbl_a", last_a1, vecs[i].ea1);
         chk("tbl_b", last_b1, vecs[i].eb1);
         chk("tbl_a_tc", last_a0, vecs[i].ea0);
         chk("tbl_b_tc", last_b0, vecs[i].eb0);
      end

      repeat (300) rand_step();

      tvalid = 1'b1;
      for (int n = 0; n < 5; n++) begin
         tdata = {16'(-n - 7), 16'(n + 7)};
         step();
      end
      areset = 1'b1;
      step();
      areset = 1'b0;
      chk("midreset_tready", tready1, 0);
      chk("midreset_dac_rst", rst1, 1);
      chk("midreset_underflow", und1, 0);
      repeat (79) rand_step();
      chk("midreset_not_yet_ready", tready1, 0);
      rand_step();
      chk("midreset_ready_again", tready1, 1);
      repeat (100) rand_step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
